// File: rtl/vga_test_pattern_controller.sv
// VGA 640x480 @ 60 Hz timing generator with an internal 8-colour vertical bar
// test pattern. All outputs are registered from the pre-increment counters, so
// the outputs after the n-th rising edge following reset release describe
// pixel n-1 of the frame scan.
//
// Build option: define VGA_GRAYSCALE_EN to output the bar colours converted
// to gray, Y = (R + 2*G + B) >> 2, on all three channels.
`timescale 1ns/1ps

module vga_test_pattern_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hSync,
    output logic       vSync,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W    = H_ACTIVE / 8;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;

    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       h_last, v_last;

    logic [7:1] bar_ge;
    logic [2:0] bar_idx;
    logic       active;
    logic [3:0] bar_r, bar_g, bar_b;

    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic [3:0] r_q, r_d;
    logic [3:0] g_q, g_d;
    logic [3:0] b_q, b_d;

    assign h_last = (hcount_q == 10'(H_TOTAL - 1));
    assign v_last = (vcount_q == 10'(V_TOTAL - 1));

    // Raster position: hcount every clock, vcount on each line wrap.
    always_comb begin
        hcount_d = h_last ? 10'd0 : hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (h_last) begin
            vcount_d = v_last ? 10'd0 : vcount_q + 10'd1;
        end
    end

    // Thermometer of bar boundaries: bar_ge[k] is set once x reaches bar k.
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_bar_cmp
            assign bar_ge[gi] = (hcount_q >= 10'(gi * BAR_W));
        end
    endgenerate

    // Bar index is the highest boundary already crossed (no divider needed).
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (bar_ge[k]) begin
                bar_idx = 3'(k);
            end
        end
    end

    // The bar order white..black maps each channel onto one index bit:
    // red is off for bars 2,3,6,7, green off for 4..7, blue off for odd bars.
    assign bar_r = {4{~bar_idx[1]}};
    assign bar_g = {4{~bar_idx[2]}};
    assign bar_b = {4{~bar_idx[0]}};

    assign active = (hcount_q < 10'(H_ACTIVE)) && (vcount_q < 10'(V_ACTIVE));

`ifdef VGA_GRAYSCALE_EN
    logic [5:0] y_sum;
    logic [3:0] y_val;

    assign y_sum = {2'b00, bar_r} + {1'b0, bar_g, 1'b0} + {2'b00, bar_b};
    assign y_val = 4'(y_sum >> 2);

    // Next output pixel: gray level in the active region, black when blanking.
    always_comb begin
        r_d = active ? y_val : 4'd0;
        g_d = active ? y_val : 4'd0;
        b_d = active ? y_val : 4'd0;
    end
`else
    // Next output pixel: bar colour in the active region, black when blanking.
    always_comb begin
        r_d = active ? bar_r : 4'd0;
        g_d = active ? bar_g : 4'd0;
        b_d = active ? bar_b : 4'd0;
    end
`endif

    // Sync pulses (active low) decoded from the current raster position.
    always_comb begin
        hsync_d = !((hcount_q >= 10'(HS_START)) && (hcount_q <= 10'(HS_END)));
        vsync_d = !((vcount_q >= 10'(VS_START)) && (vcount_q <= 10'(VS_END)));
    end

    // Counter and output registers; reset restarts the scan at pixel (0,0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount_q <= 10'd0;
            vcount_q <= 10'd0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            r_q      <= 4'd0;
            g_q      <= 4'd0;
            b_q      <= 4'd0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
        end
    end

    assign hSync = hsync_q;
    assign vSync = vsync_q;
    assign VGA_R = r_q;
    assign VGA_G = g_q;
    assign VGA_B = b_q;

endmodule

// File: tb/tb_vga_test_pattern_controller.sv
// Testbench for vga_test_pattern_controller. Full horizontal timing; the
// vertical timing parameters are shrunk so that several complete frames
// (including vSync pulses and frame wrap) fit in a short run. Every pixel is
// compared with a reference computed from the pixel index since reset.
`timescale 1ns/1ps

module tb_vga_test_pattern_controller;

    localparam int TB_V_ACTIVE = 4;
    localparam int TB_V_FP     = 2;
    localparam int TB_V_SYNC   = 2;
    localparam int TB_V_BP     = 3;
    localparam int H_TOT       = 800;
    localparam int V_TOT       = TB_V_ACTIVE + TB_V_FP + TB_V_SYNC + TB_V_BP;
    localparam int FRAME       = H_TOT * V_TOT;
    localparam int VS_FALL     = (TB_V_ACTIVE + TB_V_FP) * H_TOT + 1;
    localparam logic [15:0] IDLE = 16'h3000;

`ifdef VGA_GRAYSCALE_EN
    localparam logic [11:0] C_WHITE  = 12'hFFF;
    localparam logic [11:0] C_YELLOW = 12'hBBB;
    localparam logic [11:0] C_RED    = 12'h333;
`else
    localparam logic [11:0] C_WHITE  = 12'hFFF;
    localparam logic [11:0] C_YELLOW = 12'hFF0;
    localparam logic [11:0] C_RED    = 12'hF00;
`endif
    localparam logic [11:0] C_BLACK  = 12'h000;

    logic       clk;
    logic       reset;
    logic       clk_run;
    logic       hSync, vSync;
    logic [3:0] VGA_R, VGA_G, VGA_B;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;

    int pal_r[8] = '{15, 15, 0, 0, 15, 15, 0, 0};
    int pal_g[8] = '{15, 15, 15, 15, 0, 0, 0, 0};
    int pal_b[8] = '{15, 0, 15, 0, 15, 0, 15, 0};

    vga_test_pattern_controller #(
        .V_ACTIVE (TB_V_ACTIVE),
        .V_FP     (TB_V_FP),
        .V_SYNC   (TB_V_SYNC),
        .V_BP     (TB_V_BP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hSync (hSync),
        .vSync (vSync),
        .VGA_R (VGA_R),
        .VGA_G (VGA_G),
        .VGA_B (VGA_B)
    );

    initial clk = 1'b0;
    always begin
        #20;
        if (clk_run) clk = ~clk;
    end

    function automatic logic [15:0] dut_out();
        return {2'b00, hSync, vSync, VGA_R, VGA_G, VGA_B};
    endfunction

    // Reference: expected outputs for pixel p of the scan since reset release.
    function automatic logic [15:0] model(int p);
        int x, y, bar, r, g, b, gray;
        logic hs, vs;
        x  = p % H_TOT;
        y  = (p / H_TOT) % V_TOT;
        hs = !(x >= 656 && x < 752);
        vs = !(y >= TB_V_ACTIVE + TB_V_FP && y < TB_V_ACTIVE + TB_V_FP + TB_V_SYNC);
        r = 0; g = 0; b = 0;
        if (x < 640 && y < TB_V_ACTIVE) begin
            bar = x / 80;
            r = pal_r[bar];
            g = pal_g[bar];
            b = pal_b[bar];
`ifdef VGA_GRAYSCALE_EN
            gray = (r + 2 * g + b) / 4;
            r = gray; g = gray; b = gray;
`endif
        end
        return {2'b00, hs, vs, 4'(r), 4'(g), 4'(b)};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s (edge %0d): got %h, expected %h", tag, edge_n, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Spot checks at the boundaries named for line and frame timing.
    task automatic directed_checks();
        logic [15:0] hs_v, vs_v, rgb_v;
        hs_v  = {15'd0, hSync};
        vs_v  = {15'd0, vSync};
        rgb_v = {4'd0, VGA_R, VGA_G, VGA_B};
        if (edge_n == 1)   begin check("first_pix_rgb", rgb_v, {4'd0, C_WHITE}); check("first_pix_hs", hs_v, 16'd1); check("first_pix_vs", vs_v, 16'd1); end
        if (edge_n == 80)  check("x79_white", rgb_v, {4'd0, C_WHITE});
        if (edge_n == 81)  check("x80_yellow", rgb_v, {4'd0, C_YELLOW});
        if (edge_n == 401) check("x400_red", rgb_v, {4'd0, C_RED});
        if (edge_n == 561) check("x560_black", rgb_v, {4'd0, C_BLACK});
        if (edge_n == 640) check("x639_black", rgb_v, {4'd0, C_BLACK});
        if (edge_n == 641) check("x640_blank", rgb_v, 16'd0);
        if (edge_n == 656) check("hs_before_fall", hs_v, 16'd1);
        if (edge_n == 657) check("hs_fall", hs_v, 16'd0);
        if (edge_n == 752) check("hs_last_low", hs_v, 16'd0);
        if (edge_n == 753) check("hs_rise", hs_v, 16'd1);
        if (edge_n == 1457) check("hs_fall_line1", hs_v, 16'd0);
        if (edge_n == (TB_V_ACTIVE - 1) * H_TOT + 1) check("last_line_x0", rgb_v, {4'd0, C_WHITE});
        if (edge_n == TB_V_ACTIVE * H_TOT + 1)       check("vblank_x0", rgb_v, 16'd0);
        if (edge_n == VS_FALL - 1)         check("vs_before_fall", vs_v, 16'd1);
        if (edge_n == VS_FALL)             check("vs_fall", vs_v, 16'd0);
        if (edge_n == VS_FALL + 1599)      check("vs_last_low", vs_v, 16'd0);
        if (edge_n == VS_FALL + 1600)      check("vs_rise", vs_v, 16'd1);
        if (edge_n == VS_FALL + FRAME)     check("vs_fall_frame2", vs_v, 16'd0);
        if (edge_n == VS_FALL + FRAME - 1) check("vs_high_frame2", vs_v, 16'd1);
    endtask

    task automatic run_cycles(input int n_cyc, input bit directed);
        for (int i = 0; i < n_cyc; i++) begin
            @(posedge clk);
            #1;
            edge_n++;
            check("pixel", dut_out(), model(edge_n - 1));
            if (directed) directed_checks();
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        #3;
        reset  = 1'b0;
        edge_n = 0;
    endtask

    // Reset asserted mid-cycle: outputs must go idle without waiting for clk.
    task automatic async_reset(input int hold);
        #($urandom_range(2, 15));
        reset = 1'b1;
        #1;
        check("rst_async", dut_out(), IDLE);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold", dut_out(), IDLE);
        end
        release_reset();
    endtask

    initial begin
        int seg;
        clk_run = 1'b0;
        reset   = 1'b0;
        #7;
        reset = 1'b1;
        #3;
        check("rst_clk_stopped", dut_out(), IDLE);
        clk_run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk_running", dut_out(), IDLE);
        release_reset();
        run_cycles(2 * FRAME + 1000, 1'b1);
        $display("segment 0: %0d pixels from reset, directed boundaries included", edge_n);

        for (int s = 1; s <= 4; s++) begin
            async_reset(int'($urandom_range(1, 5)));
            seg = int'($urandom_range(100, 3000));
            run_cycles(seg, 1'b0);
            $display("segment %0d: async reset then %0d pixels", s, seg);
        end

        // Reset while the clock is stopped mid-frame.
        clk_run = 1'b0;
        #50;
        reset = 1'b1;
        #2;
        check("rst_stopped_midframe", dut_out(), IDLE);
        #50;
        clk_run = 1'b1;
        release_reset();
        run_cycles(900, 1'b1);
        $display("segment 5: stopped-clock reset then %0d pixels", edge_n);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
